// File: rtl/fetch_stage.sv
// fetch_stage: PC, ROM address and IF/ID register of the 8-bit core; ROM[pc] lands in IF/ID one edge later.
// Stall holds PC and IF/ID, redirect overrides stall/flush; the HALT state is built only with `define FETCH_HALT_EN.
module fetch_stage #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] NOP_INSTR   = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_instr,
  input  logic       stall,
  input  logic       flush,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic [7:0] ifid_instr,
  output logic [7:0] ifid_pc,
  output logic [7:0] ifid_pc_plus1,
  output logic       ifid_valid,
  output logic       halted
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pc;
  logic [7:0] w_pc_nxt;
  logic [7:0] w_pc_inc;
  logic       w_load;
  logic       w_bubble;
  logic       w_halt_hit;
  logic [7:0] r_ifid_instr;
  logic [7:0] r_ifid_pc;
  logic [7:0] r_ifid_pc_plus1;
  logic       r_ifid_valid;

  assign w_pc_inc = r_pc + 8'd1;

`ifdef FETCH_HALT_EN
  assign w_halt_hit = (imem_instr == HALT_OPCODE);
  assign halted     = (r_state == ST_HALT);
`else
  logic w_unused_halt_opcode;
  assign w_unused_halt_opcode = ^HALT_OPCODE;
  assign w_halt_hit = 1'b0;
  assign halted     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  if (!redirect && !stall && !flush && w_halt_hit) w_state_nxt = ST_HALT;
      ST_HALT: if (redirect) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // BOOT (and any illegal encoding) leaves pc and IF/ID untouched
  always_comb begin
    w_pc_nxt = r_pc;
    w_load   = 1'b0;
    w_bubble = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
          w_bubble = 1'b1;
        end else if (stall) begin
          w_bubble = flush;
        end else if (flush) begin
          w_pc_nxt = w_pc_inc;
          w_bubble = 1'b1;
        end else begin
          w_load = 1'b1;
          if (!w_halt_hit) w_pc_nxt = w_pc_inc;
        end
      end
      ST_HALT: begin
        w_bubble = 1'b1;
        if (redirect) w_pc_nxt = redirect_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc            <= RESET_PC;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc       <= 8'h00;
      r_ifid_pc_plus1 <= 8'h00;
      r_ifid_valid    <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_load) begin
        r_ifid_instr    <= imem_instr;
        r_ifid_pc       <= r_pc;
        r_ifid_pc_plus1 <= w_pc_inc;
        r_ifid_valid    <= 1'b1;
      end else if (w_bubble) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end
    end
  end

  assign imem_addr     = r_pc;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc       = r_ifid_pc;
  assign ifid_pc_plus1 = r_ifid_pc_plus1;
  assign ifid_valid    = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a cycle-level model of the fetch rules predicts every edge; a monitor compares.
module tb_fetch_stage;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [7:0] NOP = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic [7:0] imem_addr;
  logic [7:0] imem_instr;
  logic [7:0] ifid_instr;
  logic [7:0] ifid_pc;
  logic [7:0] ifid_pc_plus1;
  logic       ifid_valid;
  logic       halted;

  logic [7:0] rom [256];
  assign imem_instr = rom[imem_addr];

  fetch_stage #(.RESET_PC(8'h00), .NOP_INSTR(8'h00), .HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] instr;
    logic [7:0] pc;
    logic [7:0] pc1;
    logic       vld;
    logic       hlt;
  } exp_t;

  exp_t sb_q[$];
  event ev_chk;
  int   checks = 0;
  int   errors = 0;

  // Reference: mode 0=boot, 1=run, 2=halted
  int         m_mode;
  logic [7:0] m_pc, m_instr, m_ipc, m_ipc1;
  logic       m_vld;

  task automatic model_reset();
    m_mode = 0; m_pc = 8'h00; m_instr = NOP; m_ipc = 8'h00; m_ipc1 = 8'h00; m_vld = 1'b0;
  endtask

  task automatic bubble();
    m_instr = NOP; m_vld = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic f, input logic d, input logic [7:0] t);
    logic [7:0] op;
    if (!r) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      bubble();
      if (d) begin m_pc = t; m_mode = 1; end
    end else if (d) begin
      m_pc = t; bubble();
    end else if (s) begin
      if (f) bubble();
    end else if (f) begin
      m_pc = 8'((int'(m_pc) + 1) % 256); bubble();
    end else begin
      op = rom[m_pc];
      m_instr = op; m_ipc = m_pc; m_ipc1 = 8'((int'(m_pc) + 1) % 256); m_vld = 1'b1;
      if (HALT_EN && op == 8'hFF) m_mode = 2;
      else m_pc = 8'((int'(m_pc) + 1) % 256);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.addr = m_pc; e.instr = m_instr; e.pc = m_ipc; e.pc1 = m_ipc1; e.vld = m_vld;
    e.hlt = (m_mode == 2);
    return e;
  endfunction

  task automatic cycle(input logic r, input logic s, input logic f, input logic d, input logic [7:0] t);
    rst_n = r; stall = s; flush = f; redirect = d; redirect_pc = t;
    model_step(r, s, f, d, t);
    sb_q.push_back(model_exp());
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    sb_q.push_back(model_exp());
    -> ev_chk;
    #2;
  endtask

  // Monitor: one expectation per clock edge, plus one per mid-cycle reset
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk or ev_chk);
      #1;
      g = {imem_addr, ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid, halted};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty at %0t: no expectation queued", $time);
      end else begin
        e = sb_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL fetch_out at %0t: got addr=%h instr=%h pc=%h pc1=%h vld=%b hlt=%b, want addr=%h instr=%h pc=%h pc1=%h vld=%b hlt=%b",
                   $time, g.addr, g.instr, g.pc, g.pc1, g.vld, g.hlt,
                   e.addr, e.instr, e.pc, e.pc1, e.vld, e.hlt);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom);
      if (rom[i] == 8'hFF) rom[i] = 8'h5A;
      if ($urandom_range(0, 19) == 0) rom[i] = 8'hFF;
    end
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'hFF;
    rom[4] = 8'h44; rom[5] = 8'h55; rom[6] = 8'h66;
    rom[8'h40] = 8'hA4; rom[8'h41] = 8'hA5;
    rom[8'hFE] = 8'hEE; rom[8'hFF] = 8'hEF;
    model_reset();

    // Reset, boot cycle, first fetches
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 1, 1, 1, 8'h77);
    cycle(1, 1, 1, 1, 8'h77);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    // Stall two cycles while ifid_pc=1, then 33 at pc 2
    cycle(1, 1, 0, 0, 8'h00);
    cycle(1, 1, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    // ROM[3]=FF: halts with the macro, flows through without it
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 1, 1, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 1, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    // Redirect wins over stall
    cycle(1, 1, 0, 1, 8'h40);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    // PC wrap
    cycle(1, 0, 0, 1, 8'hFE);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    // Stall+flush at pc 5, plain flush, redirect to current pc
    cycle(1, 0, 0, 1, 8'h05);
    cycle(1, 1, 1, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 1, 0, 8'h00);
    cycle(1, 0, 0, 1, 8'h07);
    cycle(1, 0, 0, 0, 8'h00);
    // Asynchronous reset between edges, mid stall/redirect
    cycle(1, 1, 0, 1, 8'h90);
    stall = 1'b1; redirect = 1'b1;
    async_reset();
    cycle(0, 1, 0, 1, 8'h90);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, s, f, d;
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 6) == 0);
      d = ($urandom_range(0, 9) == 0);
      cycle(r, s, f, d, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
